// File: rtl/vmul_pkg.sv
// Shared types for the pipelined SIMD vedic multiplier: opcodes, lane precisions
// and the payload that travels alongside each operation through the pipe.
package vmul_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHU  = 2'b10,
    OP_MULHSU = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    PREC_8  = 2'b00,
    PREC_16 = 2'b01,
    PREC_32 = 2'b10,
    PREC_64 = 2'b11
  } prec_e;

  function automatic int unsigned lane_width(prec_e prec);
    return 32'd8 << prec;
  endfunction

  typedef struct packed {
    logic [MAX_XLEN-1:0] a;
    logic [MAX_XLEN-1:0] b;
    opcode_e             op;
    prec_e               prec;
    logic                err;
  } payload_t;

endpackage

// File: rtl/vedic_mul8.sv
// Unsigned 8x8 -> 16 Urdhva Tiryakbhyam cell: vertical/crosswise column sums,
// then one weighted accumulation resolves the column carries.
module vedic_mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [3:0] col [15];

  always_comb begin
    // NOTE: every element gets a default before the accumulation loop so no latch is inferred.
    for (int k = 0; k < 15; k++) col[k] = '0;
    // NOTE: blocking assignments here on purpose; each partial sum must see the one before it.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        col[i+j] = col[i+j] + {3'b000, a[i] & b[j]};
    p = '0;
    for (int k = 0; k < 15; k++)
      p = p + ({12'h000, col[k]} << k);
  end

endmodule

// File: rtl/vmul_pipe_param.sv
// Parametrised pipelined SIMD multiplier (8/16/32/64-bit lanes) with valid/ready
// handshake; a single global stall freezes every stage while the output is blocked.
module vmul_pipe_param #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [1:0]      opcode,
  input  logic [1:0]      precision,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mul_out,
  output logic            out_err
);

  import vmul_pkg::*;

  localparam int NB    = XLEN / 8;
  localparam int NCELL = NB * NB;
  localparam int LAST  = PIPE_STAGES;

  logic                  stall;
  logic [LAST:1]         vld_q;
  payload_t              in_pay;
  payload_t              pay_q [1:LAST-1];
  payload_t              pay_src;
  logic [15:0]           cell_pp [NCELL];
  logic [15:0]           pp_src  [NCELL];
  logic [3:0][XLEN-1:0]  res_p;
  logic [XLEN-1:0]       res_sel;
  logic                  unused_pay;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[LAST];

  always_comb begin
    in_pay      = '0;
    in_pay.a    = MAX_XLEN'(operand_a);
    in_pay.b    = MAX_XLEN'(operand_b);
    in_pay.op   = opcode_e'(opcode);
    in_pay.prec = prec_e'(precision);
    in_pay.err  = (XLEN == 32) && (prec_e'(precision) == PREC_64);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        vld_q <= '0;
    else if (!stall) vld_q <= {vld_q[LAST-1:1], in_valid};
  end

  // NOTE: datapath registers carry no reset; the valid bits alone say whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) pay_q[1] <= in_pay;
      for (int k = 2; k < LAST; k++)
        if (vld_q[k-1]) pay_q[k] <= pay_q[k-1];
    end
  end

  assign pay_src = pay_q[LAST-1];
  // Upper operand bits stay zero when XLEN is narrower than the payload.
  assign unused_pay = ^{pay_src.a, pay_src.b};

  // Every byte of a against every byte of b; each lane mode picks its own cells.
  for (genvar gi = 0; gi < NB; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      vedic_mul8 u_cell (
        .a (pay_q[1].a[8*gi +: 8]),
        .b (pay_q[1].b[8*gj +: 8]),
        .p (cell_pp[gi*NB + gj])
      );
    end
  end

  if (LAST == 2) begin : g_no_mid
    assign pp_src = cell_pp;
  end else begin : g_mid
    logic [15:0] pp_q [2:LAST-1][NCELL];

    always_ff @(posedge clk) begin
      if (!stall) begin
        if (vld_q[1]) pp_q[2] <= cell_pp;
        for (int k = 3; k < LAST; k++)
          if (vld_q[k-1]) pp_q[k] <= pp_q[k-1];
      end
    end

    assign pp_src = pp_q[LAST-1];
  end

  for (genvar gp = 0; gp < 4; gp++) begin : g_prec
    localparam int W = lane_width(prec_e'(gp));
    if (W > XLEN) begin : g_illegal
      assign res_p[gp] = '0;
    end else begin : g_legal
      for (genvar gl = 0; gl < XLEN / W; gl++) begin : g_lane
        localparam int LB = W / 8;
        localparam int LO = gl * LB;
        logic [2*W-1:0] prod;
        logic [W-1:0]   a_l;
        logic [W-1:0]   b_l;
        logic [W-1:0]   hi;

        assign a_l = pay_src.a[gl*W +: W];
        assign b_l = pay_src.b[gl*W +: W];

        // Only cells inside this lane contribute, so no carry crosses lanes.
        always_comb begin
          prod = '0;
          for (int i = 0; i < LB; i++)
            for (int j = 0; j < LB; j++)
              prod = prod + ((2*W)'(pp_src[(LO+i)*NB + LO + j]) << (8*(i+j)));
          hi = prod[2*W-1:W];
          if (pay_src.op == OP_MULH)
            hi = hi - ({W{a_l[W-1]}} & b_l) - ({W{b_l[W-1]}} & a_l);
          else if (pay_src.op == OP_MULHSU)
            hi = hi - ({W{a_l[W-1]}} & b_l);
        end

        assign res_p[gp][gl*W +: W] = (pay_src.op == OP_MUL) ? prod[W-1:0] : hi;
      end
    end
  end

  assign res_sel = res_p[pay_src.prec];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_out <= '0;
      out_err <= 1'b0;
    end else if (!stall && vld_q[LAST-1]) begin
      mul_out <= pay_src.err ? '0 : res_sel;
      out_err <= pay_src.err;
    end
  end

endmodule

// File: doc/vmul_pipe_param.md
# vmul_pipe_param

Parametrised, pipelined SIMD multiplier built on Urdhva Tiryakbhyam (vedic) 8x8 cells. It is the successor to the fixed 32-bit precision-controlled multiplier, with these additions:
- configurable datapath width;
- 8/16/32/64-bit lane modes;
- signed, unsigned and mixed high-half products;
- a valid/ready handshake with full back-pressure.

It sits between the vector register read stage and writeback.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PIPE_STAGES, 3, fixed accept-to-result latency in cycles; legal values 2..4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- operand_a  in  XLEN  packed lanes, lane 0 in LSBs.
- operand_b  in  XLEN  packed lanes.
- opcode  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHU (u×u high), 11 MULHSU (a signed × b unsigned, high).
- precision  in  2  lane width: 00 8b, 01 16b, 10 32b, 11 64b.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid & out_ready.
- mul_out  out  XLEN  packed lane results.
- out_err  out  1  illegal precision for this XLEN; qualified by out_valid.

## Operation
- Lane width W = 8 << precision; lane count = XLEN / W.
- Each lane forms a 2W-bit product. MUL returns product[W-1:0]; the high opcodes return product[2W-1:W].
- Lanes are independent; no carry crosses a lane boundary.
- Signed handling: compute the unsigned product U, then apply corrections to the high half:
  - MULH subtracts (a<0 ? b : 0) and (b<0 ? a : 0);
  - MULHSU subtracts only (a<0 ? b : 0).
- MUL low half is sign-agnostic.
- Wide lanes are built by shift-accumulating 8x8 vedic partial products.
- precision=11 with XLEN=32 is an illegal mode:
  - the op still flows through the pipe with normal latency;
  - mul_out = 0 and out_err = 1 at output.
- opcode and precision are captured with the operands on acceptance and travel with the op. Changing them while ops are in flight never affects those ops.

## Timing
- Reset (rst low, asynchronous) clears all stage valid bits and out_valid, and sets mul_out = 0, out_err = 0.
- in_ready is combinational but does not depend on in_valid.
- Reset mid-operation discards every in-flight op. No result for those ops ever appears after rst rises.
- Pipeline: PIPE_STAGES register stages, each with its own valid bit.
  - Stage 1 registers the operands and controls.
  - The middle stage(s) hold the partial products.
  - The final stage holds the selected/corrected result, which drives mul_out.
- An op accepted at edge N gives out_valid = 1 after edge N + PIPE_STAGES - 1 when there is no stall. With PIPE_STAGES = 3, out_valid is high for the cycle after the third edge.
- Global stall condition: stall = out_valid & ~out_ready.
  - While stalled, every stage holds, including bubbles.
  - in_ready = ~stall.
  - mul_out and out_err are stable.
- Throughput is one op per cycle when out_ready is held high.
- Ordering is strict FIFO; ops are never dropped or duplicated.
- Simultaneous accept and retire in the same cycle is allowed.
- When out_valid is low, mul_out holds its last value; the value is don't-care for checking.

## Structure
- Package vmul_pkg holds:
  - opcode enum (OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU);
  - precision enum (PREC_8, PREC_16, PREC_32, PREC_64);
  - function lane_width(prec);
  - the per-stage payload struct (operands, opcode, precision, err).
- Sub-module vedic_mul8 is the unsigned 8x8→16 Urdhva Tiryakbhyam cell. It is instantiated (XLEN/8)² times in a generate array.
- Top-level vmul_pipe_param contains the stage registers, handshake, lane select and sign correction.

## Test plan
- XLEN=32, precision=10, opcode=10, a=0x00000002, b=0xFFFFFFFE → mul_out=0x00000001, out_valid exactly 3 cycles after accept.
- precision=00, opcode=00, a=0x02030405, b=0x10101010 → mul_out=0x20304050.
- precision=01, opcode=01, a=0xFFFF0002, b=0x00020003 → mul_out=0xFFFF0000. Lane 1: -1×2 high = 0xFFFF; lane 0: 2×3 high = 0x0000.
- precision=10, opcode=11, a=0xFFFFFFFF, b=0x00000002 → mul_out=0xFFFFFFFF. Then precision=11 on XLEN=32 → out_err=1, mul_out=0.
- Back-pressure: accept 3 back-to-back ops, then hold out_ready=0 → in_ready=0 and the first result is stable. Release out_ready → results appear in order, one per cycle, with none lost.
- Drive rst low with 2 ops in flight → out_valid and mul_out go to 0 immediately. After rst rises, no stale result appears, and a new op completes with normal latency.
